cblock_cfg_loader: RTL and testbench

Configuration-plane stage that sits directly upstream of a column of connection blocks. It accepts a serial bitstream through a valid/ready handshake and assembles one 18-bit frame per connection block. It then presents each frame on a shared bits bus and pulses that block's one-hot wr_en, with setup and hold margins around the pulse, because the connection blocks capture on a high-enable latch. It sequences N_CBLK frames per load and reports completion.

---
 rtl/fpga_cfg_pkg.sv | 28 ++
 rtl/cblock_cfg_loader_if.sv | 25 ++
 rtl/cblock_cfg_loader_shreg.sv | 43 ++++
 rtl/cblock_cfg_loader.sv | 109 ++++++++++
 tb/tb_cblock_cfg_loader.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the connection-block configuration loader:
// frame geometry, per-field slices and the loader FSM encoding.
package fpga_cfg_pkg;

    localparam int CBLK_CFG_W = 18;

    // Field slices within one connection-block frame
    localparam int V_HI  = 17;
    localparam int V_LO  = 12;
    localparam int LU_HI = 11;
    localparam int LU_LO = 9;
    localparam int DR_HI = 8;
    localparam int DR_LO = 6;
    localparam int UR_HI = 5;
    localparam int UR_LO = 3;
    localparam int LD_HI = 2;
    localparam int LD_LO = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        SETUP = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } ldr_state_e;

endpackage

// File: rtl/cblock_cfg_loader_if.sv
// Bitstream handshake plus the shared frame bus toward the connection blocks.
interface cblock_cfg_loader_if #(
    parameter int N_CBLK  = 4,
    parameter int FRAME_W = 18
);
    logic                cfg_start;
    logic                cfg_din;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [FRAME_W-1:0]  cblk_bits;
    logic [N_CBLK-1:0]   cblk_wr_en;
    logic                busy;
    logic                done;
    logic                start_err;

    modport master (
        output cfg_start, cfg_din, cfg_valid,
        input  cfg_ready, cblk_bits, cblk_wr_en, busy, done, start_err
    );

    modport slave (
        input  cfg_start, cfg_din, cfg_valid,
        output cfg_ready, cblk_bits, cblk_wr_en, busy, done, start_err
    );
endinterface

// File: rtl/cblock_cfg_loader_shreg.sv
// Serial-in/parallel-out frame assembler; frame_o already includes the bit
// being shifted this cycle so the caller can launch it on the final accept edge.
module cfg_shift_reg
    import fpga_cfg_pkg::*;
#(
    parameter int FRAME_W = CBLK_CFG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               shift_en_i,
    input  logic               din_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic               frame_full_o
);
    localparam int CNT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign shreg_d      = {shreg_q[FRAME_W-2:0], din_i};
    assign frame_o      = shreg_d;
    assign frame_full_o = shift_en_i && (cnt_q == CNT_W'(FRAME_W-1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || frame_full_o)
            cnt_d = '0;
        else if (shift_en_i)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (shift_en_i)
                shreg_q <= shreg_d;
        end
    end
endmodule

// File: rtl/cblock_cfg_loader.sv
// Loads N_CBLK serial frames and writes each to its connection block with a
// latch-enable pulse framed by one stable-bits cycle on either side.
module cblock_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int N_CBLK   = 4,
    parameter int FRAME_W  = CBLK_CFG_W,
    parameter int WR_PULSE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    cblock_cfg_loader_if.slave  bus
);
    localparam int IDX_W = (N_CBLK > 1) ? $clog2(N_CBLK) : 1;
    localparam int PW    = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

    ldr_state_e          state_q;
    logic [IDX_W-1:0]    frame_idx_q;
    logic [PW-1:0]       pulse_cnt_q;
    logic [FRAME_W-1:0]  bits_q;
    logic [N_CBLK-1:0]   wr_en_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                xfer;
    logic                frame_full;
    logic [FRAME_W-1:0]  frame_nxt;

    assign bus.cfg_ready  = (state_q == SHIFT);
    assign xfer           = bus.cfg_valid && (state_q == SHIFT);
    assign bus.cblk_bits  = bits_q;
    assign bus.cblk_wr_en = wr_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.start_err  = err_q;

    cfg_shift_reg #(.FRAME_W(FRAME_W)) u_shreg (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (state_q == IDLE),
        .shift_en_i   (xfer),
        .din_i        (bus.cfg_din),
        .frame_o      (frame_nxt),
        .frame_full_o (frame_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_idx_q <= '0;
            pulse_cnt_q <= '0;
            bits_q      <= '0;
            wr_en_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A start outside IDLE (including DONE) never restarts the load
            if (bus.cfg_start && state_q != IDLE)
                err_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    frame_idx_q <= '0;
                    if (bus.cfg_start) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (frame_full) begin
                        bits_q  <= frame_nxt;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    wr_en_q     <= N_CBLK'(1) << frame_idx_q;
                    pulse_cnt_q <= '0;
                    state_q     <= WRITE;
                end
                WRITE: begin
                    if (pulse_cnt_q == PW'(WR_PULSE-1)) begin
                        wr_en_q <= '0;
                        state_q <= HOLD;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + PW'(1);
                    end
                end
                HOLD: begin
                    if (frame_idx_q == IDX_W'(N_CBLK-1)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        frame_idx_q <= frame_idx_q + IDX_W'(1);
                        state_q     <= SHIFT;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cblock_cfg_loader.sv
// Directed bench: a 4-block/2-cycle-pulse loader checked against a frame
// scoreboard, plus a 1-block/1-cycle-pulse loader checked inline.
module tb_cblock_cfg_loader;

    typedef struct {
        int          idx;
        logic [17:0] frame;
        int          rise;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   nwrites;
    bit   mon_en;
    exp_t sb[$];

    logic [17:0] frames [4];

    cblock_cfg_loader_if #(.N_CBLK(4), .FRAME_W(18)) ifa ();
    cblock_cfg_loader_if #(.N_CBLK(1), .FRAME_W(18)) ifb ();

    cblock_cfg_loader #(.N_CBLK(4), .FRAME_W(18), .WR_PULSE(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    cblock_cfg_loader #(.N_CBLK(1), .FRAME_W(18), .WR_PULSE(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endfunction

    // Pulse monitor for the 4-block loader
    logic [3:0]  pwe;
    logic [17:0] pbits;
    logic        pdone;
    int          plen;
    exp_t        cur;

    initial begin
        pwe   = '0;
        pbits = '0;
        pdone = 1'b0;
        plen  = 0;
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            chk("onehot0", 32'($onehot0(ifa.cblk_wr_en)), 32'd1);
            chk("done_one_cycle", 32'(ifa.done && pdone), 32'd0);
            if (ifa.cblk_wr_en != 4'd0) begin
                if (pwe == 4'd0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_write", 32'(ifa.cblk_wr_en), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        cur <= e;
                        chk("wr_en_index", 32'(ifa.cblk_wr_en), 32'd1 << e.idx);
                        chk("bits_at_rise", 32'(ifa.cblk_bits), 32'(e.frame));
                        chk("bits_setup", 32'(pbits), 32'(e.frame));
                        if (e.rise != 0)
                            chk("rise_cycle", 32'(cyc), 32'(e.rise));
                    end
                    plen <= 1;
                end else begin
                    plen <= plen + 1;
                    chk("bits_stable", 32'(ifa.cblk_bits), 32'(pbits));
                    chk("wr_en_stable", 32'(ifa.cblk_wr_en), 32'(pwe));
                end
            end else if (pwe != 4'd0) begin
                chk("pulse_len", 32'(plen), 32'd2);
                chk("bits_hold", 32'(ifa.cblk_bits), 32'(cur.frame));
                nwrites <= nwrites + 1;
            end
        end
        pwe   <= ifa.cblk_wr_en;
        pbits <= ifa.cblk_bits;
        pdone <= ifa.done;
    end

    // One load on the 4-block loader. toggle: cfg_valid alternates 1,0,...
    // start_at: extra cfg_start cycle; rst_at: pulse reset in that cycle.
    task automatic load_a(input bit toggle, input int start_at, input int rst_at,
                          output int done_at, output logic err2);
        int  k, b, guard;
        bit  take, ph;
        k = 0; b = 17; guard = 0; ph = 1'b1; done_at = 0; err2 = 1'bx;
        for (int i = 0; i < 4; i++)
            sb.push_back('{i, frames[i], toggle ? 39 + 40 * i : 21 + 22 * i});
        mon_en = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        ifa.cfg_start = 1'b1;
        while (guard < 400) begin
            if (cyc == start_at) ifa.cfg_start = 1'b1;
            if (rst_at != 0 && cyc == rst_at) begin
                mon_en = 1'b0;
                rst_n  = 1'b0;
            end
            if (rst_at != 0 && cyc == rst_at + 1) rst_n = 1'b1;
            ifa.cfg_din   = (k < 4) ? frames[k][b] : 1'b0;
            ifa.cfg_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            @(negedge clk);
            if (ifa.done && done_at == 0) done_at = cyc;
            if (cyc == 2) err2 = ifa.start_err;
            if (rst_at != 0 && cyc == rst_at + 1) begin
                chk("rst_wr_en", 32'(ifa.cblk_wr_en), 32'd0);
                chk("rst_bits", 32'(ifa.cblk_bits), 32'd0);
                chk("rst_busy", 32'(ifa.busy), 32'd0);
                chk("rst_ready", 32'(ifa.cfg_ready), 32'd0);
            end
            take = ifa.cfg_valid && ifa.cfg_ready;
            @(posedge clk); #1;
            cyc++;
            guard++;
            ifa.cfg_start = 1'b0;
            if (take && k < 4) begin
                if (b == 0) begin
                    b = 17;
                    k++;
                end else begin
                    b--;
                end
            end
            if (rst_at == 0 && done_at != 0) break;
            if (rst_at != 0 && cyc >= rst_at + 4) break;
        end
        ifa.cfg_valid = 1'b0;
        if (guard >= 400) chk("load_timeout", 32'(guard), 32'd0);
    endtask

    initial begin
        int          done_at, wr_cnt, wr_cyc, b;
        logic        err2;
        bit          take;
        logic [17:0] f1;

        frames[0] = 18'h3F000;
        frames[1] = 18'h00E07;
        frames[2] = 18'h2A955;
        frames[3] = 18'h15AAA;
        checks = 0; errors = 0; cyc = 0; nwrites = 0; mon_en = 1'b0;
        ifa.cfg_start = 1'b0; ifa.cfg_din = 1'b0; ifa.cfg_valid = 1'b0;
        ifb.cfg_start = 1'b0; ifb.cfg_din = 1'b0; ifb.cfg_valid = 1'b0;
        rst_n = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_wr_en", 32'(ifa.cblk_wr_en), 32'd0);
        chk("reset_bits", 32'(ifa.cblk_bits), 32'd0);
        chk("reset_ready", 32'(ifa.cfg_ready), 32'd0);
        chk("reset_busy", 32'(ifa.busy), 32'd0);
        chk("reset_done", 32'(ifa.done), 32'd0);
        chk("reset_err", 32'(ifa.start_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Unstalled load
        nwrites = 0;
        load_a(1'b0, 0, 0, done_at, err2);
        chk("t1_done_cycle", 32'(done_at), 32'd90);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        chk("t1_writes", 32'(nwrites), 32'd4);
        chk("t1_err", 32'(ifa.start_err), 32'd0);
        @(negedge clk);
        chk("t1_idle_busy", 32'(ifa.busy), 32'd0);

        // Stalled load, valid alternating
        nwrites = 0;
        load_a(1'b1, 0, 0, done_at, err2);
        chk("t2_done_cycle", 32'(done_at), 32'd162);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);
        chk("t2_writes", 32'(nwrites), 32'd4);

        // Start while busy during frame 1 shift
        nwrites = 0;
        load_a(1'b0, 30, 0, done_at, err2);
        chk("t3_done_cycle", 32'(done_at), 32'd90);
        chk("t3_writes", 32'(nwrites), 32'd4);
        chk("t3_err_mid", 32'(err2), 32'd0);
        @(negedge clk);
        chk("t3_err_sticky", 32'(ifa.start_err), 32'd1);

        // Reset during frame 2 WRITE; the accepted start also clears start_err
        nwrites = 0;
        load_a(1'b0, 0, 65, done_at, err2);
        chk("t4_err_cleared", 32'(err2), 32'd0);
        chk("t4_no_done", 32'(done_at), 32'd0);
        chk("t4_writes_before_rst", 32'(nwrites), 32'd2);
        sb.delete();
        nwrites = 0;
        load_a(1'b0, 0, 0, done_at, err2);
        chk("t4_reload_done", 32'(done_at), 32'd90);
        chk("t4_reload_writes", 32'(nwrites), 32'd4);
        mon_en = 1'b0;

        // Single block, single-cycle pulse
        f1 = 18'h00001;
        b = 17; wr_cnt = 0; wr_cyc = 0; done_at = 0;
        @(posedge clk); #1;
        cyc = 1;
        ifb.cfg_start = 1'b1;
        while (cyc < 40) begin
            ifb.cfg_din   = f1[b];
            ifb.cfg_valid = 1'b1;
            @(negedge clk);
            if (ifb.cblk_wr_en[0]) begin
                wr_cnt++;
                wr_cyc = cyc;
                chk("t6_bits", 32'(ifb.cblk_bits), 32'h00001);
            end
            if (ifb.done && done_at == 0) done_at = cyc;
            take = ifb.cfg_valid && ifb.cfg_ready;
            @(posedge clk); #1;
            cyc++;
            ifb.cfg_start = 1'b0;
            if (take && b > 0) b--;
        end
        ifb.cfg_valid = 1'b0;
        chk("t6_pulse_len", 32'(wr_cnt), 32'd1);
        chk("t6_rise_cycle", 32'(wr_cyc), 32'd21);
        chk("t6_done_cycle", 32'(done_at), 32'd23);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
